// File: rtl/mac_wb_arb_if.sv
// mac_wb_arb_if: ALU/MAC result streams in, register-file write-back port out
interface mac_wb_arb_if #(parameter int XLEN = 32, parameter int DEPTH = 4);
  logic                       freeze;
  logic [XLEN-1:0]            alu_out;
  logic [4:0]                 alu_rd_addr;
  logic                       alu_rd_wr_en;
  logic [XLEN-1:0]            alu_instr_tag;
  logic [31:0]                alu_instr;
  logic [XLEN-1:0]            mac_out;
  logic [4:0]                 mac_rd_addr;
  logic                       mac_rd_wr_en;
  logic [XLEN-1:0]            mac_instr_tag;
  logic [31:0]                mac_instr;
  logic                       mac_stall;
  logic [XLEN-1:0]            wb_data;
  logic [4:0]                 wb_rd_addr;
  logic                       wb_rd_wr_en;
  logic [XLEN-1:0]            wb_instr_tag;
  logic [31:0]                wb_instr;
  logic                       mac_pending;
  logic [$clog2(DEPTH+1)-1:0] fifo_count;
  modport master (
    output freeze, alu_out, alu_rd_addr, alu_rd_wr_en, alu_instr_tag, alu_instr,
           mac_out, mac_rd_addr, mac_rd_wr_en, mac_instr_tag, mac_instr,
    input  mac_stall, wb_data, wb_rd_addr, wb_rd_wr_en, wb_instr_tag, wb_instr,
           mac_pending, fifo_count
  );
  modport slave (
    input  freeze, alu_out, alu_rd_addr, alu_rd_wr_en, alu_instr_tag, alu_instr,
           mac_out, mac_rd_addr, mac_rd_wr_en, mac_instr_tag, mac_instr,
    output mac_stall, wb_data, wb_rd_addr, wb_rd_wr_en, wb_instr_tag, wb_instr,
           mac_pending, fifo_count
  );
endinterface

// File: rtl/mac_wb_arb.sv
// mac_wb_arb: merges ALU and MAC results onto one write port, buffering losing MAC results in order
module mac_wb_arb #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input logic         clk,
  input logic         rst,
  mac_wb_arb_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  typedef struct packed {
    logic [XLEN-1:0] data;
    logic [4:0]      rd;
    logic [XLEN-1:0] tag;
    logic [31:0]     instr;
  } res_t;
  res_t          mem [DEPTH];
  res_t          alu_r, mac_r, sel, wb_r;
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic          full, empty, alu_v, mac_v, push, pop, sel_v, wb_v;
  assign alu_r = {bus.alu_out, bus.alu_rd_addr, bus.alu_instr_tag, bus.alu_instr};
  assign mac_r = {bus.mac_out, bus.mac_rd_addr, bus.mac_instr_tag, bus.mac_instr};
  assign full  = cnt == CW'(DEPTH);
  assign empty = cnt == '0;
  assign alu_v = bus.alu_rd_wr_en && bus.alu_rd_addr != '0;
  // stall comes from the registered count, so a held MAC result is never taken twice
  assign mac_v = bus.mac_rd_wr_en && !full && !bus.freeze && bus.mac_rd_addr != '0;
  assign pop   = !bus.freeze && !alu_v && !empty;
  assign push  = mac_v && (alu_v || !empty);
  assign sel_v = alu_v || !empty || mac_v;
  assign sel   = alu_v ? alu_r : !empty ? mem[rp] : mac_r;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp   <= '0;
      rp   <= '0;
      cnt  <= '0;
      wb_v <= 1'b0;
      wb_r <= '0;
    end else if (!bus.freeze) begin
      wp   <= push ? wp + AW'(1) : wp;
      rp   <= pop ? rp + AW'(1) : rp;
      cnt  <= cnt + CW'(push) - CW'(pop);
      wb_v <= sel_v;
      wb_r <= sel;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= mac_r;
  end
  assign bus.mac_stall    = full;
  assign bus.mac_pending  = !empty;
  assign bus.fifo_count   = cnt;
  assign bus.wb_rd_wr_en  = wb_v && !bus.freeze;
  assign bus.wb_data      = wb_r.data;
  assign bus.wb_rd_addr   = wb_r.rd;
  assign bus.wb_instr_tag = wb_r.tag;
  assign bus.wb_instr     = wb_r.instr;
  assert property (@(posedge clk) disable iff (rst) !(push && full));
endmodule

// File: tb/tb_mac_wb_arb.sv
// tb_mac_wb_arb: directed scenarios checked against a spec-level arbiter model and write scoreboard
module tb_mac_wb_arb;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] tag;
    logic [31:0] instr;
  } res_t;
  typedef struct packed {
    logic we;
    res_t r;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  exp_t exp_q[$];
  res_t mq[$];
  bit   acc;
  int   mi;
  mac_wb_arb_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();
  mac_wb_arb #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic res_t mk(input bit is_mac, input logic [4:0] rd, input logic [31:0] d);
    mk.rd    = rd;
    mk.data  = d;
    mk.tag   = d ^ (is_mac ? 32'hB0B0_0000 : 32'hA0A0_0000);
    mk.instr = (is_mac ? 32'h0B00_0000 : 32'h0A00_0000) | {27'd0, rd};
  endfunction

  task automatic check_state();
    chk("fifo_count", 32'(bus.fifo_count), mq.size());
    chk("mac_stall", {31'd0, bus.mac_stall}, {31'd0, mq.size() == DEPTH});
    chk("mac_pending", {31'd0, bus.mac_pending}, {31'd0, mq.size() != 0});
  endtask

  // one clock of stimulus: drive, check registered state, model the selection, then score the write
  task automatic cyc(input bit ae, input logic [4:0] ar, input logic [31:0] ad,
                     input bit me, input logic [4:0] mr, input logic [31:0] md,
                     input bit frz, output bit macc);
    res_t a, m;
    exp_t e, got;
    bit   av, mv;
    a = mk(1'b0, ar, ad);
    m = mk(1'b1, mr, md);
    bus.freeze = frz;
    bus.alu_rd_wr_en = ae;  bus.alu_rd_addr = ar;  bus.alu_out = ad;
    bus.alu_instr_tag = a.tag;  bus.alu_instr = a.instr;
    bus.mac_rd_wr_en = me;  bus.mac_rd_addr = mr;  bus.mac_out = md;
    bus.mac_instr_tag = m.tag;  bus.mac_instr = m.instr;
    #1;
    check_state();
    if (frz) chk("freeze_gate", {31'd0, bus.wb_rd_wr_en}, 32'd0);
    macc = me && !frz && mq.size() != DEPTH;
    av = ae && ar != 0;
    mv = macc && mr != 0;
    e = '0;
    if (!frz) begin
      if (av) begin
        e = {1'b1, a};
        if (mv) mq.push_back(m);
      end else if (mq.size() != 0) begin
        e = {1'b1, mq.pop_front()};
        if (mv) mq.push_back(m);
      end else if (mv) e = {1'b1, m};
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    chk("wb_rd_wr_en", {31'd0, bus.wb_rd_wr_en}, {31'd0, got.we});
    if (got.we) begin
      chk("wb_data", bus.wb_data, got.r.data);
      chk("wb_rd_addr", {27'd0, bus.wb_rd_addr}, {27'd0, got.r.rd});
      chk("wb_instr_tag", bus.wb_instr_tag, got.r.tag);
      chk("wb_instr", bus.wb_instr, got.r.instr);
    end
  endtask

  task automatic idle(input int n);
    bit d;
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, d);
  endtask

  task automatic check_reset();
    chk("rst_we", {31'd0, bus.wb_rd_wr_en}, 32'd0);
    chk("rst_data", bus.wb_data, 32'd0);
    chk("rst_rd", {27'd0, bus.wb_rd_addr}, 32'd0);
    chk("rst_count", 32'(bus.fifo_count), 32'd0);
    chk("rst_stall", {31'd0, bus.mac_stall}, 32'd0);
    chk("rst_pending", {31'd0, bus.mac_pending}, 32'd0);
  endtask

  initial begin
    bus.freeze = 0;
    bus.alu_rd_wr_en = 0;  bus.alu_rd_addr = 0;  bus.alu_out = 0;
    bus.alu_instr_tag = 0;  bus.alu_instr = 0;
    bus.mac_rd_wr_en = 0;  bus.mac_rd_addr = 0;  bus.mac_out = 0;
    bus.mac_instr_tag = 0;  bus.mac_instr = 0;
    #1;
    check_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    // MAC alone bypasses the FIFO
    cyc(0, 0, 0, 1, 5'd5, 32'h10, 0, acc);
    idle(1);
    // collision: ALU wins, MAC buffered
    cyc(1, 5'd3, 32'hAA, 1, 5'd7, 32'h55, 0, acc);
    idle(2);
    // fill to full under continuous ALU traffic, then drain; MAC holds its result while stalled
    mi = 1;
    for (int c = 0; c < 14; c++) begin
      cyc(c < 6, 5'd9, 32'h100 + 32'(c), mi <= 5, 5'd10, 32'(mi), 0, acc);
      if (acc) mi++;
    end
    // pop and push in the same cycle
    cyc(1, 5'd1, 32'h11, 1, 5'd2, 32'hA, 0, acc);
    cyc(1, 5'd1, 32'h12, 1, 5'd2, 32'hB, 0, acc);
    cyc(0, 0, 0, 1, 5'd2, 32'hC, 0, acc);
    idle(3);
    // x0 destinations are dropped
    cyc(0, 0, 0, 1, 5'd0, 32'hDEAD, 0, acc);
    cyc(1, 5'd0, 32'hBEEF, 0, 0, 0, 0, acc);
    idle(1);
    // freeze with two buffered entries
    cyc(1, 5'd4, 32'h44, 1, 5'd6, 32'h61, 0, acc);
    cyc(1, 5'd4, 32'h45, 1, 5'd6, 32'h62, 0, acc);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 1, acc);
    idle(3);
    // async reset mid-drain with three buffered entries
    for (int i = 0; i < 3; i++) cyc(1, 5'd8, 32'h80 + 32'(i), 1, 5'd12, 32'hC0 + 32'(i), 0, acc);
    bus.alu_rd_wr_en = 0;
    bus.mac_rd_wr_en = 0;
    rst = 1'b1;
    #1;
    check_reset();
    mq.delete();
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mac_wb_arb.md
Name: mac_wb_arb

Overview:
- Write-back arbiter sitting directly downstream of the pipelined MAC unit and the single-cycle ALU.
- Merges both result streams onto the single register-file write port.
- ALU results always win the port. MAC results that lose arbitration are buffered in an order-preserving FIFO.
- When the FIFO fills, the block back-pressures the MAC through mac_stall.

Parameters:
- XLEN, 32, datapath and instruction-tag width.
- DEPTH, 4, MAC result FIFO entries; power of two, >=2.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-high
- freeze  in  1  global pipeline freeze
- alu_out  in  XLEN  ALU result data
- alu_rd_addr  in  5  ALU destination register
- alu_rd_wr_en  in  1  ALU result valid
- alu_instr_tag  in  XLEN  ALU instruction tag
- alu_instr  in  32  ALU instruction word
- mac_out  in  XLEN  MAC result data
- mac_rd_addr  in  5  MAC destination register
- mac_rd_wr_en  in  1  MAC result valid
- mac_instr_tag  in  XLEN  MAC instruction tag
- mac_instr  in  32  MAC instruction word
- mac_stall  out  1  hold request to MAC (ORed into its freeze)
- wb_data  out  XLEN  register-file write data
- wb_rd_addr  out  5  register-file write address
- wb_rd_wr_en  out  1  register-file write enable
- wb_instr_tag  out  XLEN  retired instruction tag
- wb_instr  out  32  retired instruction word
- mac_pending  out  1  FIFO non-empty (decode hazard hint)
- fifo_count  out  $clog2(DEPTH+1)  FIFO occupancy

Behaviour:
- Reset (rst=1, async): all outputs and FIFO pointers and count go to 0; wb_* = 0, mac_stall=0, mac_pending=0. Reset mid-operation discards buffered results.
- Qualified inputs:
  - alu_v = alu_rd_wr_en & (alu_rd_addr!=0)
  - mac_acc = mac_rd_wr_en & ~mac_stall & ~freeze
  - mac_v = mac_acc & (mac_rd_addr!=0)
- x0 results are consumed and discarded: never buffered, never written.
- mac_stall = (fifo_count==DEPTH), decoded from the registered count. It is conservative: it stays high during a drain cycle.
- Selection each non-frozen cycle, in priority order:
  1. alu_v: ALU result selected. If mac_v, the MAC result is pushed.
  2. else FIFO non-empty: head popped and selected. If mac_v, the MAC result is pushed in the same cycle; count unchanged.
  3. else mac_v: MAC result bypasses the FIFO and is selected directly.
  4. else bubble.
- Latency:
  - The selected result is registered into wb_* on the next clk edge (1-cycle latency).
  - wb_rd_wr_en=1 only if a result was selected; a bubble registers wb_rd_wr_en=0, and the other wb_* fields are don't-care.
- Ordering: MAC results retire in MAC issue order. ALU results can overtake buffered MAC results; hazard protection uses mac_pending.
- FIFO full and alu_v: no pop. mac_stall stays high, so the MAC is held and its held result is not re-accepted. The ALU is never stalled.
- Full and no alu_v: head is popped; count becomes DEPTH-1; mac_stall drops on the next cycle.
- freeze=1: no push, no pop, no wb_* register update, count and pointers held. wb_rd_wr_en output is gated to 0 during freeze to prevent a duplicate write; it reasserts when freeze drops if the register holds a valid result.
- Pointers wrap modulo DEPTH. Count is never >DEPTH or <0; push when full is impossible by construction (assertion).
- mac_pending = (fifo_count!=0).

Test Plan:
- MAC-only: mac_rd_wr_en=1, rd=5, data 0x0000_0010, no ALU -> next cycle wb_rd_wr_en=1, wb_rd_addr=5, wb_data=0x10, fifo_count stays 0.
- Collision: ALU rd=3 data 0xAA and MAC rd=7 data 0x55 in the same cycle -> cycle+1 writes r3=0xAA, fifo_count=1, mac_pending=1; cycle+2 writes r7=0x55, count=0.
- Fill/backpressure (DEPTH=4):
  - Stimulus: ALU valid every cycle plus MAC valid results 1..5.
  - Required: count reaches 4 and mac_stall=1; result 5 is held by the MAC and not accepted.
  - Then drop ALU: FIFO drains 1,2,3,4 in order, then 5 is accepted; no loss, no duplicate.
- Simultaneous pop/push: count=2 (entries A,B), MAC pushes C, no ALU -> writes A, count stays 2; then B, C in order.
- x0 and freeze:
  - MAC rd=0 valid -> no write, count unchanged.
  - freeze=1 for 3 cycles with count=2 -> wb_rd_wr_en=0 and count=2 throughout; after release, entries drain in order.
- Async reset mid-drain: count=3, assert rst between edges -> outputs and count 0 immediately, mac_stall=0, no writes after release until new input.
